// File: rtl/status_led_driver_if.sv
// rtl/status_led_driver_if.sv - link/activity/error inputs and LED outputs of status_led_driver.
interface status_led_driver_if #(
    parameter int N_CH = 2
);
    logic            rdy;
    logic [N_CH-1:0] act;
    logic            err;
    logic            err_clr;
    logic            green;
    logic            red;
    logic [N_CH-1:0] act_led;

    modport master (
        output rdy, act, err, err_clr,
        input  green, red, act_led
    );

    modport slave (
        input  rdy, act, err, err_clr,
        output green, red, act_led
    );
endinterface

// File: rtl/status_led_driver.sv
// rtl/status_led_driver.sv - bi-colour link LED plus stretched per-channel activity LEDs.
// Optional macro LED_ACTIVE_LOW_EN inverts all LED outputs inside their output registers.
module status_led_driver #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 26,
    parameter int BLINK_BIT = 21
) (
    input  logic                clk,
    input  logic                rst,
    status_led_driver_if.slave  bus
);
`ifdef LED_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BLINK_BIT:0] BLINK_ONE = {{BLINK_BIT{1'b0}}, 1'b1};

    logic [N_CH-1:0]  r_act_meta;
    logic [N_CH-1:0]  r_act_s;
    logic             r_err_meta;
    logic             r_err_s;
    logic [BLINK_BIT:0] r_blink_cnt;
    logic [CNT_W-1:0] r_su_cnt;
    logic [CNT_W-1:0] r_hold [N_CH];
    logic             r_err_lat;
    logic             r_green;
    logic             r_red;
    logic [N_CH-1:0]  r_act_led;

    logic [N_CH-1:0]  w_active;
    logic             w_blink;
    logic             w_green_nxt;
    logic             w_red_nxt;
    logic [N_CH-1:0]  w_act_led_nxt;

    // act and err may come from other domains; two flops each.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_meta <= '0;
            r_act_s    <= '0;
            r_err_meta <= 1'b0;
            r_err_s    <= 1'b0;
        end else begin
            r_act_meta <= bus.act;
            r_act_s    <= r_act_meta;
            r_err_meta <= bus.err;
            r_err_s    <= r_err_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.rdy) begin
            r_blink_cnt <= '0;
            r_su_cnt    <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
            if (!r_su_cnt[CNT_W-1])
                r_su_cnt <= r_su_cnt + CNT_ONE;
        end
    end

    // Stretch counters rest at all ones (expired); activity restarts them from zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst || !bus.rdy)
                r_hold[i] <= '1;
            else if (r_act_s[i])
                r_hold[i] <= '0;
            else if (!r_hold[i][CNT_W-1])
                r_hold[i] <= r_hold[i] + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err_lat <= 1'b0;
        else if (r_err_s)
            r_err_lat <= 1'b1;
        else if (bus.err_clr)
            r_err_lat <= 1'b0;
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < N_CH; i++)
            w_active[i] = ~r_hold[i][CNT_W-1];
    end

    assign w_blink = r_blink_cnt[BLINK_BIT];

    always_comb begin
        w_green_nxt   = 1'b0;
        w_red_nxt     = 1'b1;
        w_act_led_nxt = '0;
        if (bus.rdy) begin
            w_green_nxt = (|w_active) ? w_blink : 1'b1;
            for (int i = 0; i < N_CH; i++)
                w_act_led_nxt[i] = w_active[i] ? w_blink : 1'b1;
            if (r_err_lat)
                w_red_nxt = w_blink;
            else
                w_red_nxt = ~r_su_cnt[CNT_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_green   <= OUT_INV;
            r_red     <= ~OUT_INV;
            r_act_led <= {N_CH{OUT_INV}};
        end else begin
            r_green   <= w_green_nxt ^ OUT_INV;
            r_red     <= w_red_nxt ^ OUT_INV;
            r_act_led <= w_act_led_nxt ^ {N_CH{OUT_INV}};
        end
    end

    assign bus.green   = r_green;
    assign bus.red     = r_red;
    assign bus.act_led = r_act_led;
endmodule

// File: doc/status_led_driver.md
Name: status_led_driver

Overview:
- Parametrised board-status LED driver for the Aurora FPGA link; successor to the single-pair red/green status driver.
- Drives a bi-colour link LED (red/green) plus N_CH per-channel activity LEDs from link-ready, per-channel activity strobes and a sticky error input.
- Activity strobes are stretched to human-visible blink intervals.
- Sits at top level between link/DMA control logic and the LED pins, in the 33 MHz local clock domain.

Parameters:
- N_CH, 2: number of activity channels (1..8).
- CNT_W, 26: width of the stretch and startup counters; interval = 2^(CNT_W-1) clocks (about 1.0 s at 33 MHz).
- BLINK_BIT, 21: bit of the free-running blink counter used as blink phase; period = 2^(BLINK_BIT+1) clocks.

Ports:
- clk, input, 1: 33 MHz clock.
- rst, input, 1: synchronous reset, active-high.
- rdy, input, 1: link ready, synchronous to clk.
- act, input, N_CH: per-channel activity strobes (e.g. FIFO wr_en/rd_en); may be asynchronous.
- err, input, 1: error level or pulse; may be asynchronous.
- err_clr, input, 1: clears the latched error; synchronous to clk.
- green, output, 1: link LED green.
- red, output, 1: link LED red.
- act_led, output, N_CH: per-channel activity LEDs.

Behaviour:
- All outputs are registered. Reset values: green=0, red=1, act_led=0. All internal state is cleared or preset by rst (see below).
- Synchronisers:
  - act[i] and err each pass through 2 flops, giving act_s[i] and err_s. Reset clears them.
- Blink counter blink_cnt, BLINK_BIT+1 bits:
  - rst or ~rdy: cleared.
  - Otherwise increments every clock and wraps freely.
  - blink = blink_cnt[BLINK_BIT].
- Startup counter su_cnt, CNT_W bits:
  - rst or ~rdy: cleared.
  - Otherwise increments while MSB=0, then holds with MSB=1. It never wraps.
- Per-channel stretch counter hold[i], CNT_W bits:
  - rst or ~rdy: preset to all ones (expired).
  - Else if act_s[i]=1: cleared to 0.
  - Else increments while MSB=0, then holds.
  - active[i] = ~hold[i][CNT_W-1].
  - A continuous act keeps the counter at 0. A single-cycle strobe yields exactly 2^(CNT_W-1) active clocks.
- Error latch err_lat:
  - rst: 0.
  - err_s=1: set.
  - err_clr=1 and err_s=0: cleared. If set and clear coincide, set wins.
  - ~rdy does not clear err_lat.
- act_led[i]: ~rdy gives 0; active[i] gives blink; otherwise 1 (solid when idle and link up).
- green: ~rdy gives 0; any active[i] gives blink; otherwise 1.
- red priority:
  1. ~rdy gives 1.
  2. err_lat gives blink.
  3. Otherwise ~su_cnt[CNT_W-1]: red stays on for 2^(CNT_W-1) clocks after rdy rises, then goes off.
- Latency:
  - act high at clock edge k: act_s high after edge k+1, hold cleared at edge k+2, act_led/green follow blink from edge k+3.
  - rdy falling at edge k: outputs reach their ~rdy values at edge k+1.
- rdy dropping mid-stretch aborts every stretch immediately. When rdy returns, the startup interval is re-run.
- act asserted while ~rdy has no effect. Stretching begins only once rdy=1 and act_s=1.
- rst mid-operation overrides everything on the next edge.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- Defined: green, red and act_led are inverted inside their output registers. Reset values become green=1, red=0, act_led=all ones, so pins are driven low to light the LED.
- Undefined: active-high outputs exactly as above.
- Internal logic is identical in both cases; only the output polarity changes.

Test Plan:
Sim parameters: N_CH=2, CNT_W=6 (interval 32 clocks), BLINK_BIT=2 (period 8 clocks); macro undefined.
1. Reset and link-down: rst 1 for 2 cycles with rdy=0 -> green=0, red=1, act_led=00 held while rdy=0.
2. Startup: raise rdy -> red=1 for 32 clocks (plus 1 register cycle), then red=0; green=1 and act_led=11 from the first edge after rdy.
3. Activity stretch: single-cycle act[0] pulse at edge k -> act_led[0] and green toggle every 4 clocks from edge k+3 for 32 clocks, then return solid 1; act_led[1] stays 1 throughout.
4. Error latch: 1-cycle err pulse -> red blinks with period 8 until err_clr pulse; err and err_clr asserted together (err_s coincident) -> err_lat stays set.
5. Link drop mid-stretch: rdy=0 during an active stretch -> next edge green=0, act_led=00, red=1; rdy=1 again -> startup interval repeats and no stale activity blink.
6. LED_ACTIVE_LOW_EN defined: repeat test 1 -> green=1, red=0, act_led=11.
